// File: rtl/fifo_word_packer_if.sv
// Purpose: bundles the FIFO read port and the packed-word valid/ready port of fifo_word_packer.
// Latency: wiring only, no storage.
// Backpressure: word_ready_i stalls the word port; empty_i stalls the read port.
interface fifo_word_packer_if #(
    parameter int DATA_W         = 8,
    parameter int BYTES_PER_WORD = 4
);
    localparam int WORD_W = DATA_W * BYTES_PER_WORD;
    localparam int CNT_W  = $clog2(BYTES_PER_WORD) + 1;

    // FIFO read side
    logic              empty_i;
    logic [DATA_W-1:0] data_i;
    logic              rd_en_o;
    // packed word side
    logic [WORD_W-1:0] word_o;
    logic              word_valid_o;
    logic              word_ready_i;
    logic [CNT_W-1:0]  byte_cnt_o;

    // packer side
    modport master (
        input  empty_i, data_i, word_ready_i,
        output rd_en_o, word_o, word_valid_o, byte_cnt_o
    );

    // FIFO + downstream consumer side
    modport slave (
        output empty_i, data_i, word_ready_i,
        input  rd_en_o, word_o, word_valid_o, byte_cnt_o
    );
endinterface

// File: rtl/fifo_word_packer.sv
// Purpose: pops bytes from an 8-bit FIFO and packs BYTES_PER_WORD of them (first byte in lane 0) into one word.
// Latency: 2 cycles from the last rd_en_o of a word to word_valid_o; 1 byte/cycle sustained while filling.
// Backpressure: word held stable and popping stops while word_valid_o && !word_ready_i; no pop while empty_i.
// Optional: define PACKER_FLUSH_EN to flush a partial word after TIMEOUT idle cycles.
module fifo_word_packer #(
    parameter int DATA_W         = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int TIMEOUT        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_word_packer_if.master    bus
);
    localparam int WORD_W = DATA_W * BYTES_PER_WORD;
    localparam int CNT_W  = $clog2(BYTES_PER_WORD) + 1;

    if (BYTES_PER_WORD < 2 || TIMEOUT < 1) begin : g_cfg_err
        $error("fifo_word_packer: BYTES_PER_WORD must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic {
        FILL = 1'b0,
        OUT  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    collected_q, collected_d;
    logic                inflight_q, inflight_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic                rd_en;

`ifdef PACKER_FLUSH_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0]   idle_q, idle_d;
`endif

    // The in-flight byte is counted so a word never gets more bytes than it has lanes.
    assign rd_en = !rst && (state_q == FILL) && !bus.empty_i
                   && ((collected_q + CNT_W'(inflight_q)) < CNT_W'(BYTES_PER_WORD));

    assign bus.rd_en_o      = rd_en;
    assign bus.word_o       = word_q;
    assign bus.word_valid_o = valid_q;
    assign bus.byte_cnt_o   = byte_cnt_q;

    // Next-state: capture the in-flight byte into its lane, close the word, release it on handshake.
    always_comb begin
        state_d     = state_q;
        collected_d = collected_q;
        inflight_d  = rd_en;
        word_d      = word_q;
        valid_d     = valid_q;
        byte_cnt_d  = byte_cnt_q;
`ifdef PACKER_FLUSH_EN
        idle_d      = idle_q;
`endif
        case (state_q)
            FILL: begin
                if (inflight_q) begin
                    for (int k = 0; k < BYTES_PER_WORD; k++) begin
                        if (collected_q == CNT_W'(k)) begin
                            word_d[k*DATA_W +: DATA_W] = bus.data_i;
                        end
                    end
                    collected_d = collected_q + CNT_W'(1);
                    if (collected_d == CNT_W'(BYTES_PER_WORD)) begin
                        state_d    = OUT;
                        valid_d    = 1'b1;
                        byte_cnt_d = CNT_W'(BYTES_PER_WORD);
                    end
                end
`ifdef PACKER_FLUSH_EN
                // Idle = partial word, nothing popped, nothing in flight.
                if (rd_en) begin
                    idle_d = '0;
                end else if (!inflight_q && (collected_q != '0)) begin
                    if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                        idle_d     = '0;
                        state_d    = OUT;
                        valid_d    = 1'b1;
                        byte_cnt_d = collected_q;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
`endif
            end
            OUT: begin
                if (bus.word_ready_i) begin
                    state_d     = FILL;
                    valid_d     = 1'b0;
                    word_d      = '0;
                    collected_d = '0;
                    byte_cnt_d  = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State register; reset discards any partial word and in-flight byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            collected_q <= '0;
            inflight_q  <= 1'b0;
            word_q      <= '0;
            valid_q     <= 1'b0;
            byte_cnt_q  <= '0;
`ifdef PACKER_FLUSH_EN
            idle_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            collected_q <= collected_d;
            inflight_q  <= inflight_d;
            word_q      <= word_d;
            valid_q     <= valid_d;
            byte_cnt_q  <= byte_cnt_d;
`ifdef PACKER_FLUSH_EN
            idle_q      <= idle_d;
`endif
        end
    end
endmodule

// File: tb/tb_fifo_word_packer.sv
// Purpose: directed bench for fifo_word_packer with a byte-stream reference model and a per-cycle compare.
// Latency: model expects word_valid_o two cycles after the pop of a word's last byte.
// Backpressure: bench drops word_ready_i to stall words and drains/refills its FIFO model to exercise empty_i.
module tb_fifo_word_packer;
    localparam int DW  = 8;
    localparam int BPW = 4;
    localparam int TO  = 16;
    localparam int WW  = DW * BPW;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_word_packer_if #(.DATA_W(DW), .BYTES_PER_WORD(BPW)) bus ();

    fifo_word_packer #(.DATA_W(DW), .BYTES_PER_WORD(BPW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // FIFO model feeding the DUT
    logic [DW-1:0] fifo_q[$];
    bit            pop_req = 1'b0;

    // Reference model: bytes handed to the packer since the last delivered word
    logic [DW-1:0] popped[$];
    bit            m_valid    = 1'b0;
    bit            m_last_pop = 1'b0;
    int            m_idle     = 0;
    bit            armed      = 1'b0;
    int            vcyc       = 0;

    // Words the consumer accepted
    logic [WW-1:0] acc_words[$];
    int            acc_cnts[$];
    int            acc_vcyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WW-1:0] pack_model();
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < popped.size() && i < BPW; i++) w[i*DW +: DW] = popped[i];
        return w;
    endfunction

    // Compare against the model, then advance the model to the state after the coming edge.
    always @(negedge clk) begin
        bit exp_rd;
        if (armed) begin
            exp_rd = !rst && !m_valid && !bus.empty_i && (popped.size() < BPW);
            chk("rd_en", 64'(bus.rd_en_o), 64'(exp_rd));
            chk("word_valid", 64'(bus.word_valid_o), 64'(m_valid));
            chk("byte_cnt", 64'(bus.byte_cnt_o), 64'(m_valid ? popped.size() : 0));
            if (m_valid) chk("word", 64'(bus.word_o), 64'(pack_model()));
        end
        if (rst) begin
            popped.delete();
            m_valid    = 1'b0;
            m_last_pop = 1'b0;
            m_idle     = 0;
            vcyc       = 0;
            pop_req    = 1'b0;
            armed      = 1'b1;
        end else begin
            pop_req = bus.rd_en_o;
            if (bus.word_valid_o) vcyc++;
            if (m_valid) begin
                if (bus.word_ready_i) begin
                    acc_words.push_back(bus.word_o);
                    acc_cnts.push_back(int'(bus.byte_cnt_o));
                    acc_vcyc.push_back(vcyc);
                    vcyc = 0;
                    popped.delete();
                    m_valid = 1'b0;
                    m_idle  = 0;
                end
            end else if (popped.size() == BPW) begin
                m_valid = 1'b1;
            end
`ifdef PACKER_FLUSH_EN
            else if (popped.size() > 0 && !bus.rd_en_o && !m_last_pop) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_valid = 1'b1;
                    m_idle  = 0;
                end
            end
`endif
            if (bus.rd_en_o) begin
                popped.push_back(fifo_q.size() > 0 ? fifo_q[0] : 8'hEE);
                m_idle = 0;
            end
            m_last_pop = bus.rd_en_o;
        end
    end

    // FIFO model: read data one cycle after a pop; 0xEE marks "no valid data"
    always @(posedge clk) begin
        #1;
        if (pop_req && fifo_q.size() > 0) bus.data_i = fifo_q.pop_front();
        else bus.data_i = 8'hEE;
        #2;
        bus.empty_i = (fifo_q.size() == 0);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_acc(input int prev, input int lim, input string name);
        int k;
        k = 0;
        while (acc_words.size() == prev && k < lim) begin
            cyc(1);
            k++;
        end
        chk({name, " accepted"}, 64'(acc_words.size() > prev), 64'(1));
    endtask

    initial begin
        int n;
        int k;
        rst              = 1'b1;
        bus.word_ready_i = 1'b1;
        bus.data_i       = 8'hEE;
        fifo_q           = '{8'h11, 8'h22, 8'h33, 8'h44};
        bus.empty_i      = 1'b0;

        // reset held 2 cycles with FIFO non-empty
        cyc(1);
        chk("reset rd_en", 64'(bus.rd_en_o), 64'(0));
        chk("reset word", 64'(bus.word_o), 64'(0));
        chk("reset valid", 64'(bus.word_valid_o), 64'(0));
        chk("reset byte_cnt", 64'(bus.byte_cnt_o), 64'(0));
        cyc(1);
        chk("reset rd_en 2", 64'(bus.rd_en_o), 64'(0));
        chk("reset no pop", 64'(fifo_q.size()), 64'(4));
        rst = 1'b0;

        // full word, ready held high
        n = acc_words.size();
        wait_acc(n, 20, "full");
        chk("full word", 64'(acc_words[n]), 64'(32'h44332211));
        chk("full byte_cnt", 64'(acc_cnts[n]), 64'(4));
        chk("full valid cycles", 64'(acc_vcyc[n]), 64'(1));

        // backpressure: 5 stalled cycles with FIFO still holding data
        bus.word_ready_i = 1'b0;
        fifo_q = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'h9A, 8'h9B, 8'h9C};
        k = 0;
        while (!bus.word_valid_o && k < 20) begin
            cyc(1);
            k++;
        end
        chk("bp valid seen", 64'(bus.word_valid_o), 64'(1));
        for (int i = 0; i < 5; i++) begin
            chk("bp rd_en held low", 64'(bus.rd_en_o), 64'(0));
            chk("bp word held", 64'(bus.word_o), 64'(32'h88776655));
            cyc(1);
        end
        chk("bp fifo untouched", 64'(fifo_q.size()), 64'(4));
        n = acc_words.size();
        bus.word_ready_i = 1'b1;
        wait_acc(n, 5, "bp");
        chk("bp word", 64'(acc_words[n]), 64'(32'h88776655));
        chk("bp valid cycles", 64'(acc_vcyc[n]), 64'(6));
        wait_acc(n + 1, 20, "bp next");
        chk("bp next word", 64'(acc_words[n+1]), 64'(32'h9C9B9A99));

        // empty gap mid-word
        n = acc_words.size();
        fifo_q = '{8'hAA, 8'hBB};
        cyc(8);
        chk("gap no word", 64'(acc_words.size()), 64'(n));
        chk("gap fifo drained", 64'(fifo_q.size()), 64'(0));
        fifo_q = '{8'hCC, 8'hDD};
        wait_acc(n, 20, "gap");
        chk("gap word", 64'(acc_words[n]), 64'(32'hDDCCBBAA));

        // reset after 3 bytes, third byte still in flight
        fifo_q = '{8'hE1, 8'hE2, 8'hE3};
        cyc(3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        n = acc_words.size();
        fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        wait_acc(n, 20, "post-reset");
        chk("post-reset word", 64'(acc_words[n]), 64'(32'h04030201));
        cyc(10);
        chk("post-reset single word", 64'(acc_words.size()), 64'(n + 1));

        // lone byte followed by a long empty stretch
        n = acc_words.size();
        fifo_q = '{8'h5A};
        cyc(40);
`ifdef PACKER_FLUSH_EN
        chk("flush accepted", 64'(acc_words.size()), 64'(n + 1));
        chk("flush word", 64'(acc_words[n]), 64'(32'h0000005A));
        chk("flush byte_cnt", 64'(acc_cnts[n]), 64'(1));
`else
        chk("no flush word", 64'(acc_words.size()), 64'(n));
        chk("no flush valid", 64'(bus.word_valid_o), 64'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
